// File: rtl/sync_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_frame_tx                                                    |
// | Brief    : Serial frame transmitter: sync word, latched payload, idle gap.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sync_frame_tx #(
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'b11001011,
    parameter int                DATA_W    = 8,
    parameter int                GAP_LEN   = 2,
    parameter logic              IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam int c_FIELD_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    // Widened only if the gap is longer than both fields.
    localparam int c_CNT_MAX   = (GAP_LEN > c_FIELD_MAX) ? GAP_LEN : c_FIELD_MAX;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX) + 1;
    localparam int c_SH_W      = SYNC_W + DATA_W;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SYNC_LST = c_CNT_W'(SYNC_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LST  = c_CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SYNC = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    logic [1:0]         r_state,  w_state_nx;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [c_SH_W-1:0]  r_shift,  w_shift_nx;
    logic               r_bit,    w_bit_nx;
    logic               r_valid,  w_valid_nx;
    logic               r_busy,   w_busy_nx;
    logic               r_done,   w_done_nx;
    logic [c_SH_W-1:0]  w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= IDLE_BIT;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_bit   <= w_bit_nx;
            r_valid <= w_valid_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // Sync word and payload share one shifter; its MSB is always the next line bit.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_bit_nx   = IDLE_BIT;
        w_valid_nx = 1'b0;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_load     = {SYNC_WORD, data_in};

        case (r_state)
            c_IDLE: begin
                w_cnt_nx = '0;
                if (start) begin
                    w_state_nx = c_SYNC;
                    w_cnt_nx   = c_SYNC_LST;
                    w_shift_nx = w_load << 1;
                    w_bit_nx   = w_load[c_SH_W-1];
                    w_valid_nx = 1'b1;
                    w_busy_nx  = 1'b1;
                end
            end

            c_SYNC, c_DATA: begin
                w_bit_nx   = r_shift[c_SH_W-1];
                w_shift_nx = r_shift << 1;
                w_valid_nx = 1'b1;
                w_busy_nx  = 1'b1;
                w_cnt_nx   = r_cnt - c_CNT_ONE;
                if (r_cnt == '0) begin
                    if (r_state == c_SYNC) begin
                        w_state_nx = c_DATA;
                        w_cnt_nx   = c_DATA_LST;
                    end else begin
                        // Frame complete: the done cycle is the first gap cycle.
                        w_shift_nx = r_shift;
                        w_bit_nx   = IDLE_BIT;
                        w_valid_nx = 1'b0;
                        w_done_nx  = 1'b1;
                        if (GAP_LEN > 0) begin
                            w_state_nx = c_GAP;
                            w_cnt_nx   = c_GAP_LST;
                            w_busy_nx  = 1'b1;
                        end else begin
                            w_state_nx = c_IDLE;
                            w_cnt_nx   = '0;
                            w_busy_nx  = 1'b0;
                        end
                    end
                end
            end

            c_GAP: begin
                w_busy_nx = 1'b1;
                w_cnt_nx  = r_cnt - c_CNT_ONE;
                if (r_cnt == '0) begin
                    w_state_nx = c_IDLE;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                end
            end

            default: begin
                w_state_nx = c_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign tx_bit   = r_bit;
    assign tx_valid = r_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sync_frame_tx                                                 |
// | Brief    : Directed self-checking bench for sync_frame_tx.                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sync_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with the default gap
    logic       rst, start, tx_bit, tx_valid, busy, done;
    logic [7:0] data_in;
    logic [1:0] state;

    // Instance with no gap, feeding a sequence-detector model
    logic       rst_z, start_z, tx_bit_z, tx_valid_z, busy_z, done_z;
    logic [7:0] data_in_z;
    logic [1:0] state_z;

    sync_frame_tx #(.GAP_LEN(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .done(done), .state(state)
    );

    sync_frame_tx #(.GAP_LEN(0)) dut_z (
        .clk(clk), .rst(rst_z), .start(start_z), .data_in(data_in_z),
        .tx_bit(tx_bit_z), .tx_valid(tx_valid_z), .busy(busy_z), .done(done_z), .state(state_z)
    );

    // 11001011 detector on the serial line
    logic [7:0] det_sh;
    logic       y;
    always_ff @(posedge clk) begin
        if (rst_z) det_sh <= 8'h00;
        else       det_sh <= {det_sh[6:0], tx_bit_z};
    end
    assign y = (det_sh == 8'hCB);

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] data;
        logic       e_bit;
        logic       e_valid;
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_state;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [7:0] d);
        rst = r; start = s; data_in = d;
        @(posedge clk); #1;
    endtask

    task automatic step_z(input logic r, input logic s, input logic [7:0] d);
        rst_z = r; start_z = s; data_in_z = d;
        @(posedge clk); #1;
    endtask

    task automatic add(input logic r, input logic s, input logic [7:0] d, input logic b,
                       input logic v, input logic bz, input logic dn, input logic [1:0] st);
        vec_t t;
        t.rst = r; t.start = s; t.data = d;
        t.e_bit = b; t.e_valid = v; t.e_busy = bz; t.e_done = dn; t.e_state = st;
        vq.push_back(t);
    endtask

    // Vector k produces cycle k of a frame accepted at edge 0; k in [ig_lo,ig_hi] retries start with FF.
    task automatic add_frame(input logic [7:0] pay, input int ig_lo, input int ig_hi);
        logic [7:0] sw;
        logic       s;
        logic [7:0] d;
        sw = 8'b11001011;
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) begin
                s = 1'b1; d = pay;
            end else if (k >= ig_lo && k <= ig_hi) begin
                s = 1'b1; d = 8'hFF;
            end else begin
                s = 1'b0; d = ~pay;
            end
            if (k <= 8)       add(0, s, d, sw[8-k],   1, 1, 0, 2'd1);
            else if (k <= 16) add(0, s, d, pay[16-k], 1, 1, 0, 2'd2);
            else if (k == 17) add(0, s, d, 0, 0, 1, 1, 2'd3);
            else if (k == 18) add(0, s, d, 0, 0, 1, 0, 2'd3);
            else              add(0, s, d, 0, 0, 0, 0, 2'd0);
        end
    endtask

    initial begin
        int done_cnt;
        int vcnt[3];
        int ycnt;
        logic exp_v, exp_y;

        rst = 1'b1; start = 1'b0; data_in = 8'h00;
        rst_z = 1'b1; start_z = 1'b0; data_in_z = 8'h00;

        add(1, 0, 8'h00, 0, 0, 0, 0, 2'd0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 2'd0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 2'd0);
        add_frame(8'hA5, 1, 0);
        add_frame(8'h3C, 6, 9);

        done_cnt = 0;
        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].start, vq[i].data);
            chk($sformatf("v%0d tx_bit", i),   32'(tx_bit),   32'(vq[i].e_bit));
            chk($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(vq[i].e_valid));
            chk($sformatf("v%0d busy", i),     32'(busy),     32'(vq[i].e_busy));
            chk($sformatf("v%0d done", i),     32'(done),     32'(vq[i].e_done));
            chk($sformatf("v%0d state", i),    32'(state),    32'(vq[i].e_state));
            if (done === 1'b1) done_cnt++;
        end
        chk("table done pulses", 32'(done_cnt), 32'd2);

        // Reset asserted at edge 5 of a frame abandons it
        step(0, 1, 8'h96);
        for (int k = 2; k <= 5; k++) step(0, 0, 8'h00);
        chk("pre-reset tx_valid", 32'(tx_valid), 32'd1);
        step(1, 0, 8'h00);
        chk("mid-reset tx_bit",   32'(tx_bit),   32'd0);
        chk("mid-reset tx_valid", 32'(tx_valid), 32'd0);
        chk("mid-reset busy",     32'(busy),     32'd0);
        chk("mid-reset state",    32'(state),    32'd0);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 8'h00);
            if (done === 1'b1 || tx_valid === 1'b1) done_cnt++;
        end
        chk("post-reset activity", 32'(done_cnt), 32'd0);

        // GAP_LEN=0, start held high: frames at cycles 1-16, 18-33, 35-50
        step_z(1, 0, 8'h00);
        step_z(1, 0, 8'h00);
        vcnt = '{0, 0, 0};
        ycnt = 0;
        for (int c = 1; c <= 51; c++) begin
            step_z(0, 1, 8'h00);
            exp_v = (c >= 1 && c <= 16) || (c >= 18 && c <= 33) || (c >= 35 && c <= 50);
            exp_y = (c == 9) || (c == 26) || (c == 43);
            chk($sformatf("b2b c%0d tx_valid", c), 32'(tx_valid_z), 32'(exp_v));
            chk($sformatf("loop c%0d y", c),       32'(y),          32'(exp_y));
            if (tx_valid_z === 1'b1) vcnt[(c - 1) / 17]++;
            if (y === 1'b1) ycnt++;
            if (c == 17) begin
                chk("b2b done c17",  32'(done_z),  32'd1);
                chk("b2b state c17", 32'(state_z), 32'd0);
            end
            if (c == 18) chk("b2b first sync bit c18", 32'(tx_bit_z), 32'd1);
        end
        for (int f = 0; f < 3; f++) chk($sformatf("b2b frame%0d valid count", f), 32'(vcnt[f]), 32'd16);
        chk("loop y count", 32'(ycnt), 32'd3);
        start_z = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
